// File: rtl/niosqsys_input_pio.sv
// Avalon-MM input PIO: synchronises, debounces and edge-captures external
// input bits, and raises a maskable level interrupt toward the Nios II.
module niosqsys_input_pio #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] clr;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic             wr_en;
  logic             unused_wd;

  // Only the low WIDTH bits of writedata carry meaning.
  assign unused_wd = ^writedata;

  assign wr_en = chipselect & ~write_n;

  // Two-flop synchroniser for the asynchronous inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: accept a new level only after it has differed from the
  // filtered level for DEBOUNCE_CYCLES consecutive samples; flag matching edges.
  always_comb begin
    filt_d = filt_q;
    evt    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
        if (EDGE_TYPE == 0) begin
          evt[i] = sync2_q[i];
        end else if (EDGE_TYPE == 1) begin
          evt[i] = ~sync2_q[i];
        end else begin
          evt[i] = 1'b1;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Bus writes: mask register and write-one-to-clear of the capture bits;
  // a fresh event beats a simultaneous clear.
  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr_en && (address == 2'd1)) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == 2'd3)) begin
      clr = writedata[WIDTH-1:0];
    end
    cap_d = evt | (cap_q & ~clr);
  end

  // Filter, counter, mask and capture state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Zero-wait-state read mux, independent of chipselect.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = filt_q;
      2'd1:    readdata[WIDTH-1:0] = mask_q;
      2'd3:    readdata[WIDTH-1:0] = cap_q;
      default: readdata = '0;
    endcase
  end

  // Interrupt is a pure function of registers, so it never glitches.
  assign irq = |(cap_q & mask_q);

endmodule
